// File: rtl/pipeline_controller.sv
// Purpose: pipeline sequencer for stall, flush and bubble controls, load-use detection, HALT drain and single-step gating.
// Latency: controls are combinational in the same cycle; state, drain counter and cycle count update on the next edge.
// Backpressure: a non-advance cycle (step mode with no i_step, or HALTED) drops every enable and holds all state.
module pipeline_controller #(
  parameter int NB_ADDR      = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int NB_CYCLE     = 32
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_debug_mode,
  input  logic                i_step,
  input  logic                i_ex_memRead,
  input  logic [NB_ADDR-1:0]  i_ex_rt,
  input  logic [NB_ADDR-1:0]  i_id_rs,
  input  logic [NB_ADDR-1:0]  i_id_rt,
  input  logic                i_id_jump,
  input  logic                i_id_halt,
  output logic                o_pipe_en,
  output logic                o_pc_we,
  output logic                o_ifid_we,
  output logic                o_ifid_flush,
  output logic                o_idex_bubble,
  output logic                o_halted,
  output logic [1:0]          o_state,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state;
  logic [NB_DRAIN-1:0]  drain_cnt;
  logic [NB_CYCLE-1:0]  cycle_cnt;
  logic                 adv;
  logic                 lu;

  assign adv = (state != HALTED) && (!i_debug_mode || i_step);
  assign lu  = i_ex_memRead && (i_ex_rt != '0) &&
               ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

  always_comb begin
    o_pipe_en     = 1'b0;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_halted      = 1'b0;
    o_state       = 2'd0;
    o_cycle_count = '0;
    if (!i_rst) begin
      o_pipe_en     = adv;
      o_halted      = (state == HALTED);
      o_state       = state;
      o_cycle_count = cycle_cnt;
      if (adv) begin
        // HALT and load-use both hold fetch/decode; drain keeps bubbling until WB retires
        if ((state == DRAIN) || i_id_halt || lu) begin
          o_idex_bubble = 1'b1;
        end else begin
          o_pc_we      = 1'b1;
          o_ifid_we    = 1'b1;
          o_ifid_flush = i_id_jump;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      cycle_cnt <= '0;
    end else if (adv) begin
      cycle_cnt <= cycle_cnt + NB_CYCLE'(1);
      case (state)
        RUN: begin
          if (i_id_halt) begin
            state     <= DRAIN;
            drain_cnt <= NB_DRAIN'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - NB_DRAIN'(1);
          if (drain_cnt == NB_DRAIN'(1)) state <= HALTED;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: directed scenarios then randomized traffic, each cycle's expected controls queued
// from a drain-countdown reference model and compared by an independent monitor on the falling edge.
module tb_pipeline_controller;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_debug_mode, i_step, i_ex_memRead, i_id_jump, i_id_halt;
  logic [4:0]  i_ex_rt, i_id_rs, i_id_rt;
  logic        o_pipe_en, o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_halted;
  logic [1:0]  o_state;
  logic [31:0] o_cycle_count;

  typedef struct packed {
    logic        pipe_en;
    logic        pc_we;
    logic        ifid_we;
    logic        flush;
    logic        bubble;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: cycles of drain still owed (0 = not draining), halted flag, advance count
  int          m_drain  = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_count  = '0;

  pipeline_controller #(.NB_ADDR(5), .DRAIN_CYCLES(DRAIN), .NB_CYCLE(32)) dut (
    .clk(clk), .i_rst(i_rst), .i_debug_mode(i_debug_mode), .i_step(i_step),
    .i_ex_memRead(i_ex_memRead), .i_ex_rt(i_ex_rt), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_jump(i_id_jump), .i_id_halt(i_id_halt),
    .o_pipe_en(o_pipe_en), .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we),
    .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble), .o_halted(o_halted),
    .o_state(o_state), .o_cycle_count(o_cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit dbg, input bit step, input bit memrd,
                     input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                     input bit jump, input bit halt);
    exp_t e;
    bit   adv, lu;
    @(posedge clk);
    #1;
    i_rst = rst; i_debug_mode = dbg; i_step = step; i_ex_memRead = memrd;
    i_ex_rt = ex_rt; i_id_rs = rs; i_id_rt = rt; i_id_jump = jump; i_id_halt = halt;
    e = '0;
    adv = !m_halted && (!dbg || step);
    lu  = memrd && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    if (!rst) begin
      e.pipe_en = adv;
      e.halted  = m_halted;
      e.state   = m_halted ? 2'd2 : (m_drain > 0 ? 2'd1 : 2'd0);
      e.count   = m_count;
      if (adv) begin
        if (m_drain > 0 || halt || lu) e.bubble = 1'b1;
        else begin
          e.pc_we = 1'b1; e.ifid_we = 1'b1; e.flush = jump;
        end
      end
    end
    exp_q.push_back(e);
    if (rst) begin
      m_drain = 0; m_halted = 1'b0; m_count = '0;
    end else if (adv) begin
      m_count = m_count + 1;
      if (m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) m_halted = 1'b1;
      end else if (halt) m_drain = DRAIN;
    end
  endtask

  task automatic idle(input bit dbg, input int n);
    for (int k = 0; k < n; k++) cyc(0, dbg, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a control word every cycle; compare against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pipe_en",     32'(o_pipe_en),     32'(e.pipe_en));
        chk("pc_we",       32'(o_pc_we),       32'(e.pc_we));
        chk("ifid_we",     32'(o_ifid_we),     32'(e.ifid_we));
        chk("ifid_flush",  32'(o_ifid_flush),  32'(e.flush));
        chk("idex_bubble", 32'(o_idex_bubble), 32'(e.bubble));
        chk("halted",      32'(o_halted),      32'(e.halted));
        chk("state",       32'(o_state),       32'(e.state));
        chk("cycle_count", o_cycle_count,      e.count);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired queue=%0d expected 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_debug_mode = 1'b0; i_step = 1'b0; i_ex_memRead = 1'b0;
    i_ex_rt = '0; i_id_rs = '0; i_id_rt = '0; i_id_jump = 1'b0; i_id_halt = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2);
    // load-use, then r0 never hazards
    cyc(0, 0, 0, 1, 5, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // jump alone, then jump with load-use on rt
    cyc(0, 0, 0, 0, 3, 1, 2, 1, 0);
    cyc(0, 0, 0, 1, 7, 1, 7, 1, 0);
    // halt in continuous run
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 7);
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // step mode: no steps, then three isolated pulses
    idle(1, 10);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
      idle(1, 2);
    end
    // halt accepted on a step, drain with idle gaps, then steps into HALTED
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < DRAIN; k++) begin
      idle(1, 3);
      cyc(0, 1, 1, 1, 4, 4, 4, 1, 1);
    end
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset with two drain cycles still owed
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2);
    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 29) == 0));
    end
    @(posedge clk);
    @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
